// File: rtl/lock_supervisor.sv
// Supervisor between keypad and two-digit combination lock: edge-detects Enter, tracks results, relock/lockout timers, reprogramming.
// Latency: one cycle from sampled key press or lock result to registered outputs (LockEnter/LockDigit/LockClear/state).
// Backpressure: none; presses arriving outside ARMED (or while a lock result is being handled) are dropped, never queued.
module lock_supervisor #(
  parameter int          MAX_FAILS      = 3,
  parameter int          OPEN_CYCLES    = 500,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter int          CNT_WIDTH      = 16,
  parameter logic [3:0]  DEFAULT_D1     = 4'h2,
  parameter logic [3:0]  DEFAULT_D2     = 4'h3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       EnterBtn,
  input  logic [3:0] Digit,
  input  logic       Program,
  input  logic       LockOpen,
  input  logic       LockFail,
  output logic       LockEnter,
  output logic [3:0] LockDigit,
  output logic       LockClear,
  output logic [3:0] Combo1,
  output logic [3:0] Combo2,
  output logic [2:0] State,
  output logic       Unlocked,
  output logic       LockedOut,
  output logic [1:0] FailCount
);

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_ARMED   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_PROG1   = 3'd3,
    ST_PROG2   = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  // Timer reload values are "cycles minus one" so the state is held for
  // exactly the configured number of cycles, exiting on the zero count.
  localparam logic [CNT_WIDTH-1:0] OPEN_LOAD    = CNT_WIDTH'(OPEN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOCKOUT_LOAD = CNT_WIDTH'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]           MAX_F        = 2'(MAX_FAILS);

  state_t               state_q, state_nxt;
  logic [CNT_WIDTH-1:0] timer_q, timer_nxt;
  logic [1:0]           fail_q, fail_nxt;
  logic [3:0]           staged_q, staged_nxt;
  logic [3:0]           combo1_q, combo1_nxt;
  logic [3:0]           combo2_q, combo2_nxt;
  logic                 enter_q, enter_nxt;
  logic [3:0]           digit_q, digit_nxt;
  logic                 clear_q;
  logic                 prev_q;
  logic                 press;

  // A press is the rising edge of the already-synchronized Enter level.
  // prev resets high so a button held through reset is not seen as a press.
  assign press = EnterBtn & ~prev_q;

  // Next-state, timer, failure count, programming and lock-drive decisions.
  always_comb begin
    state_nxt  = state_q;
    timer_nxt  = timer_q;
    fail_nxt   = fail_q;
    staged_nxt = staged_q;
    combo1_nxt = combo1_q;
    combo2_nxt = combo2_q;
    enter_nxt  = 1'b0;
    digit_nxt  = digit_q;
    case (state_q)
      ST_CLEAR: begin
        state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        // A lock result always wins over a simultaneous press; Fail wins over Open.
        if (LockFail) begin
          fail_nxt = fail_q + 2'd1;
          if (fail_nxt == MAX_F) begin
            state_nxt = ST_LOCKOUT;
            timer_nxt = LOCKOUT_LOAD;
          end else begin
            state_nxt = ST_CLEAR;
          end
        end else if (LockOpen) begin
          fail_nxt  = 2'd0;
          state_nxt = ST_OPEN;
          timer_nxt = OPEN_LOAD;
        end else if (press) begin
          enter_nxt = 1'b1;
          digit_nxt = Digit;
        end
      end
      ST_OPEN: begin
        // Timeout takes precedence over a press landing on the last open cycle.
        if (timer_q == '0) begin
          state_nxt = ST_CLEAR;
        end else begin
          timer_nxt = timer_q - 1'b1;
          if (press) begin
            state_nxt = Program ? ST_PROG1 : ST_CLEAR;
          end
        end
      end
      ST_PROG1: begin
        if (!Program) begin
          state_nxt = ST_CLEAR;
        end else if (press) begin
          staged_nxt = Digit;
          state_nxt  = ST_PROG2;
        end
      end
      ST_PROG2: begin
        // Both digits commit on the same edge so the lock never sees half a combination.
        if (!Program) begin
          state_nxt = ST_CLEAR;
        end else if (press) begin
          combo1_nxt = staged_q;
          combo2_nxt = Digit;
          state_nxt  = ST_CLEAR;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_nxt = ST_CLEAR;
          fail_nxt  = 2'd0;
        end else begin
          timer_nxt = timer_q - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= ST_CLEAR;
      timer_q  <= '0;
      fail_q   <= 2'd0;
      staged_q <= 4'd0;
      combo1_q <= DEFAULT_D1;
      combo2_q <= DEFAULT_D2;
      enter_q  <= 1'b0;
      digit_q  <= 4'd0;
      clear_q  <= 1'b0;
      prev_q   <= 1'b1;
    end else begin
      state_q  <= state_nxt;
      timer_q  <= timer_nxt;
      fail_q   <= fail_nxt;
      staged_q <= staged_nxt;
      combo1_q <= combo1_nxt;
      combo2_q <= combo2_nxt;
      enter_q  <= enter_nxt;
      digit_q  <= digit_nxt;
      // Pulse is registered from the CLEAR state, so it lands in the cycle
      // after CLEAR and never asserts while reset is held.
      clear_q  <= (state_q == ST_CLEAR);
      prev_q   <= EnterBtn;
    end
  end

  assign LockEnter = enter_q;
  assign LockDigit = digit_q;
  assign LockClear = clear_q;
  assign Combo1    = combo1_q;
  assign Combo2    = combo2_q;
  assign State     = state_q;
  assign Unlocked  = (state_q == ST_OPEN);
  assign LockedOut = (state_q == ST_LOCKOUT);
  assign FailCount = fail_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// Self-checking bench for lock_supervisor: vector table, directed corner sequences, random stimulus vs reference model.
// Latency: outputs compared half a cycle after each rising edge.
// Backpressure: not applicable; bench drives inputs freely every cycle.
module tb_lock_supervisor;

  localparam int MAXF    = 3;
  localparam int OPENC   = 500;
  localparam int LOCKC   = 1000;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       EnterBtn = 1'b0;
  logic [3:0] Digit = 4'd0;
  logic       Program = 1'b0;
  logic       LockOpen = 1'b0;
  logic       LockFail = 1'b0;
  logic       LockEnter;
  logic [3:0] LockDigit;
  logic       LockClear;
  logic [3:0] Combo1;
  logic [3:0] Combo2;
  logic [2:0] State;
  logic       Unlocked;
  logic       LockedOut;
  logic [1:0] FailCount;

  int tests = 0;
  int fails = 0;

  lock_supervisor #(
    .MAX_FAILS(MAXF), .OPEN_CYCLES(OPENC), .LOCKOUT_CYCLES(LOCKC),
    .CNT_WIDTH(16), .DEFAULT_D1(4'h2), .DEFAULT_D2(4'h3)
  ) dut (
    .Clock(Clock), .Reset(Reset), .EnterBtn(EnterBtn), .Digit(Digit),
    .Program(Program), .LockOpen(LockOpen), .LockFail(LockFail),
    .LockEnter(LockEnter), .LockDigit(LockDigit), .LockClear(LockClear),
    .Combo1(Combo1), .Combo2(Combo2), .State(State), .Unlocked(Unlocked),
    .LockedOut(LockedOut), .FailCount(FailCount)
  );

  always #5 Clock = ~Clock;

  // Reference model: lock situation tracked as "remaining open/lockout cycles",
  // a programming stage and a pending-clear flag.
  bit m_prev = 1'b1;
  bit m_in_clear = 1'b1;
  int m_open_left = 0;
  int m_lock_left = 0;
  int m_prog = 0;
  int m_fails = 0;
  int m_c1 = 2;
  int m_c2 = 3;
  int m_staged = 0;
  bit e_enter = 1'b0;
  bit e_clear = 1'b0;
  int e_digit = 0;

  function automatic void go_clear();
    m_in_clear  = 1'b1;
    m_prog      = 0;
    m_open_left = 0;
  endfunction

  function automatic int exp_state();
    if (m_in_clear) return 0;
    if (m_lock_left > 0) return 5;
    if (m_prog == 1) return 3;
    if (m_prog == 2) return 4;
    if (m_open_left > 0) return 2;
    return 1;
  endfunction

  always @(posedge Clock) begin : model
    bit press;
    press = EnterBtn && !m_prev;
    if (!Reset) begin
      m_prev = 1'b1; m_in_clear = 1'b1; m_open_left = 0; m_lock_left = 0;
      m_prog = 0; m_fails = 0; m_c1 = 2; m_c2 = 3; m_staged = 0;
      e_enter = 1'b0; e_clear = 1'b0; e_digit = 0;
    end else begin
      m_prev  = EnterBtn;
      e_enter = 1'b0;
      e_clear = m_in_clear;
      if (m_in_clear) begin
        m_in_clear = 1'b0;
      end else if (m_lock_left > 0) begin
        m_lock_left--;
        if (m_lock_left == 0) begin
          m_in_clear = 1'b1;
          m_fails = 0;
        end
      end else if (m_prog != 0) begin
        if (!Program) go_clear();
        else if (press) begin
          if (m_prog == 1) begin
            m_staged = int'(Digit);
            m_prog = 2;
          end else begin
            m_c1 = m_staged;
            m_c2 = int'(Digit);
            go_clear();
          end
        end
      end else if (m_open_left > 0) begin
        m_open_left--;
        if (m_open_left == 0) m_in_clear = 1'b1;
        else if (press) begin
          if (Program) m_prog = 1;
          else go_clear();
        end
      end else begin
        if (LockFail) begin
          m_fails++;
          if (m_fails == MAXF) m_lock_left = LOCKC;
          else m_in_clear = 1'b1;
        end else if (LockOpen) begin
          m_fails = 0;
          m_open_left = OPENC;
        end else if (press) begin
          e_enter = 1'b1;
          e_digit = int'(Digit);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model.State", State, exp_state());
    check("model.LockEnter", LockEnter, e_enter);
    check("model.LockClear", LockClear, e_clear);
    check("model.FailCount", FailCount, m_fails);
    check("model.Unlocked", Unlocked, exp_state() == 2);
    check("model.LockedOut", LockedOut, exp_state() == 5);
    check("model.Combo1", Combo1, m_c1);
    check("model.Combo2", Combo2, m_c2);
    if (e_enter) check("model.LockDigit", LockDigit, e_digit);
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
    compare_model();
  endtask

  task automatic press_key(input logic [3:0] d);
    EnterBtn = 1'b1; Digit = d;
    tick();
    EnterBtn = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    Reset = 1'b0; EnterBtn = 1'b0; Program = 1'b0; LockOpen = 1'b0; LockFail = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic open_lock();
    LockOpen = 1'b1;
    tick();
    LockOpen = 1'b0;
  endtask

  typedef struct {
    bit rst; bit btn; logic [3:0] dig; bit prog; bit opn; bit fl;
    logic [2:0] st; bit en; bit clr; logic [1:0] fc; bit unl; bit lko;
  } vec_t;

  vec_t vt[18];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int lo, unl, n;
    bit saw_enter;
    //          rst btn dig prog opn fl | st en clr fc unl lko
    vt[0]  = '{0, 1, 4'd0, 0, 0, 0,   3'd0, 0, 0, 2'd0, 0, 0};
    vt[1]  = '{0, 1, 4'd0, 0, 0, 0,   3'd0, 0, 0, 2'd0, 0, 0};
    vt[2]  = '{1, 1, 4'd0, 0, 0, 0,   3'd1, 0, 1, 2'd0, 0, 0};
    vt[3]  = '{1, 1, 4'd0, 0, 0, 0,   3'd1, 0, 0, 2'd0, 0, 0};
    vt[4]  = '{1, 0, 4'd0, 0, 0, 0,   3'd1, 0, 0, 2'd0, 0, 0};
    vt[5]  = '{1, 1, 4'd2, 0, 0, 0,   3'd1, 1, 0, 2'd0, 0, 0};
    vt[6]  = '{1, 0, 4'd2, 0, 0, 0,   3'd1, 0, 0, 2'd0, 0, 0};
    vt[7]  = '{1, 1, 4'd3, 0, 0, 0,   3'd1, 1, 0, 2'd0, 0, 0};
    vt[8]  = '{1, 0, 4'd3, 0, 1, 0,   3'd2, 0, 0, 2'd0, 1, 0};
    vt[9]  = '{1, 1, 4'd0, 0, 0, 0,   3'd0, 0, 0, 2'd0, 0, 0};
    vt[10] = '{1, 0, 4'd0, 0, 0, 0,   3'd1, 0, 1, 2'd0, 0, 0};
    vt[11] = '{1, 0, 4'd0, 0, 0, 1,   3'd0, 0, 0, 2'd1, 0, 0};
    vt[12] = '{1, 0, 4'd0, 0, 0, 0,   3'd1, 0, 1, 2'd1, 0, 0};
    vt[13] = '{1, 0, 4'd0, 0, 1, 1,   3'd0, 0, 0, 2'd2, 0, 0};
    vt[14] = '{1, 0, 4'd0, 0, 0, 0,   3'd1, 0, 1, 2'd2, 0, 0};
    vt[15] = '{1, 1, 4'd7, 0, 0, 1,   3'd5, 0, 0, 2'd3, 0, 1};
    vt[16] = '{1, 0, 4'd0, 0, 0, 0,   3'd5, 0, 0, 2'd3, 0, 1};
    vt[17] = '{1, 1, 4'd0, 0, 0, 0,   3'd5, 0, 0, 2'd3, 0, 1};

    // Vector table: reset with button held, an opening attempt, failures, lockout entry.
    for (int i = 0; i < 18; i++) begin
      Reset = vt[i].rst; EnterBtn = vt[i].btn; Digit = vt[i].dig;
      Program = vt[i].prog; LockOpen = vt[i].opn; LockFail = vt[i].fl;
      tick();
      check($sformatf("vec%0d.State", i), State, vt[i].st);
      check($sformatf("vec%0d.LockEnter", i), LockEnter, vt[i].en);
      check($sformatf("vec%0d.LockClear", i), LockClear, vt[i].clr);
      check($sformatf("vec%0d.FailCount", i), FailCount, vt[i].fc);
      check($sformatf("vec%0d.Unlocked", i), Unlocked, vt[i].unl);
      check($sformatf("vec%0d.LockedOut", i), LockedOut, vt[i].lko);
      if (vt[i].en) check($sformatf("vec%0d.LockDigit", i), LockDigit, vt[i].dig);
      if (i == 1) begin
        check("reset.Combo1", Combo1, 4'h2);
        check("reset.Combo2", Combo2, 4'h3);
      end
    end
    LockFail = 1'b0;

    // Lockout duration with presses hammered throughout.
    lo = 3; saw_enter = 1'b0; n = 0;
    while (n < 1100) begin
      EnterBtn = ~EnterBtn;
      tick();
      n++;
      if (LockEnter) saw_enter = 1'b1;
      if (LockedOut) lo++;
      else break;
    end
    EnterBtn = 1'b0;
    check("lockout.cycles", lo, LOCKC);
    check("lockout.no_enter", saw_enter, 1'b0);
    check("lockout.exit_state", State, 3'd0);
    check("lockout.fails_cleared", FailCount, 2'd0);

    // Auto-relock timing after a successful attempt.
    do_reset();
    press_key(4'd2);
    press_key(4'd3);
    open_lock();
    unl = Unlocked ? 1 : 0;
    n = 0;
    while (n < 600) begin
      tick();
      n++;
      if (Unlocked) unl++;
      else break;
    end
    check("open.cycles", unl, OPENC);
    check("open.relock_state", State, 3'd0);
    check("open.fails", FailCount, 2'd0);
    tick();
    check("open.clear_pulse", LockClear, 1'b1);
    check("open.armed", State, 3'd1);

    // Reprogram to 5/9.
    open_lock();
    Program = 1'b1;
    press_key(4'd0);
    check("prog.state_prog1", State, 3'd3);
    press_key(4'd5);
    check("prog.state_prog2", State, 3'd4);
    check("prog.no_midchange", Combo1, 4'h2);
    press_key(4'd9);
    check("prog.combo1", Combo1, 4'h5);
    check("prog.combo2", Combo2, 4'h9);
    // Abandon a second programming attempt in PROG2.
    tick();
    open_lock();
    press_key(4'd0);
    press_key(4'd7);
    Program = 1'b0;
    tick();
    check("abort.state", State, 3'd0);
    check("abort.combo1", Combo1, 4'h5);
    check("abort.combo2", Combo2, 4'h9);
    tick();

    // Reset mid-programming discards staged digit and restores defaults.
    open_lock();
    Program = 1'b1;
    press_key(4'd0);
    press_key(4'd7);
    check("rstprog.in_prog2", State, 3'd4);
    Reset = 1'b0;
    tick();
    check("rstprog.State", State, 3'd0);
    check("rstprog.Combo1", Combo1, 4'h2);
    check("rstprog.Combo2", Combo2, 4'h3);
    check("rstprog.LockClear", LockClear, 1'b0);
    check("rstprog.LockEnter", LockEnter, 1'b0);
    check("rstprog.Unlocked", Unlocked, 1'b0);
    check("rstprog.FailCount", FailCount, 2'd0);
    Reset = 1'b1; Program = 1'b0;
    tick();
    check("rstprog.clear_after", LockClear, 1'b1);

    // Random stimulus against the reference model.
    for (int c = 0; c < 4000; c++) begin
      Reset    = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 2) == 0) EnterBtn = ~EnterBtn;
      Digit    = 4'($urandom_range(0, 15));
      Program  = ($urandom_range(0, 9) < 8);
      LockOpen = ($urandom_range(0, 14) == 0);
      LockFail = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lock_supervisor.md
# lock_supervisor

Supervisory controller that sits between the keypad and the two-digit combination lock FSM. It single-pulses key presses into the lock, watches the lock's Open/Fail result, enforces an auto-relock timer and a lockout after repeated failures, and lets an open lock be reprogrammed with a new two-digit combination that it drives to the lock as configuration.

## Interface
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout (≥1, ≤3).
- OPEN_CYCLES, 500: cycles the lock stays open before auto-relock (≥1).
- LOCKOUT_CYCLES, 1000: cycles Enter is ignored after lockout (≥1).
- CNT_WIDTH, 16: timer width; must hold max(OPEN_CYCLES, LOCKOUT_CYCLES)-1.
- DEFAULT_D1, 4'h2 / DEFAULT_D2, 4'h3: combination loaded at reset.
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- EnterBtn  in  1  keypad Enter level, already synchronized to Clock.
- Digit  in  4  keypad digit value.
- Program  in  1  level; reprogram request, honoured only while open.
- LockOpen  in  1  lock's Open output.
- LockFail  in  1  lock's Fail output.
- LockEnter  out  1  registered one-cycle Enter pulse to lock.
- LockDigit  out  4  registered digit, valid with LockEnter.
- LockClear  out  1  registered one-cycle pulse returning lock to its initial state.
- Combo1, Combo2  out  4  each  configured combination digits to lock.
- State  out  3  current supervisor state encoding.
- Unlocked  out  1  high in OPEN.
- LockedOut  out  1  high in LOCKOUT.
- FailCount  out  2  consecutive failures since last success/lockout.

## Operation
- Edge detect: press = EnterBtn & ~prev; prev resets to 1 so a button held through reset produces no press.
- States: CLEAR=0, ARMED=1, OPEN=2, PROG1=3, PROG2=4, LOCKOUT=5; codes 6/7 go to CLEAR next cycle.
- CLEAR: LockClear=1 for this one cycle; next ARMED. Reset enters CLEAR.
- ARMED: press -> LockEnter=1, LockDigit=Digit next cycle. LockFail=1 (priority over LockOpen if both) -> FailCount+1; if new count==MAX_FAILS -> LOCKOUT, timer=LOCKOUT_CYCLES-1, else -> CLEAR. LockOpen=1 -> OPEN, FailCount=0, timer=OPEN_CYCLES-1. Press and Open/Fail in same cycle: result handled, press dropped.
- OPEN: timer decrements each cycle; timer==0 -> CLEAR. Press with Program=0 -> CLEAR (manual relock). Press with Program=1 -> PROG1, timer frozen.
- PROG1: press -> stage Digit as new D1 -> PROG2. Program=0 -> CLEAR, combo unchanged.
- PROG2: press -> Combo1=staged D1, Combo2=Digit (same edge) -> CLEAR. Program=0 -> CLEAR, combo unchanged.
- LOCKOUT: presses ignored (no LockEnter); timer==0 -> CLEAR, FailCount=0.
- No LockEnter pulses outside ARMED. Program ignored outside OPEN/PROG1/PROG2.

## Timing
- Reset values: State=CLEAR, LockEnter=0, LockClear=0 (asserts first cycle after Reset deasserts), LockDigit=0, Combo1=DEFAULT_D1, Combo2=DEFAULT_D2, Unlocked=0, LockedOut=0, FailCount=0, timer=0.
- Press sampled at edge n -> LockEnter/LockDigit high during cycle n+1 only.
- LockOpen first high at edge n -> Unlocked high cycles n+1..n+OPEN_CYCLES, CLEAR at n+OPEN_CYCLES+1.
- Lockout: LockedOut high for exactly LOCKOUT_CYCLES cycles.
- Combo change visible one cycle after PROG2 press; never changes mid-attempt.
- Reset low in any state, including PROG2 mid-entry: full reset next edge, staged digit discarded, combination reverts to defaults.
- Unlocked, LockedOut, State all registered/decoded from state register; no input-to-output combinational paths.

## Test plan
- Reset with EnterBtn held high -> one LockClear pulse, no LockEnter; Combo1=2, Combo2=3, State=1 after 2 cycles.
- Press digits 2 then 3, lock returns LockOpen -> Unlocked high exactly 500 cycles, FailCount=0, then LockClear pulse, State=1.
- Three attempts each ending LockFail -> FailCount 1,2 then LockedOut for 1000 cycles; presses during it give no LockEnter; FailCount=0 after.
- Open, Program=1, press digit 5, press digit 9 -> Combo1=5, Combo2=9, LockClear; drop Program in PROG2 on repeat -> combo stays 5/9.
- LockOpen and LockFail high together in ARMED -> treated as fail (FailCount+1, no Unlocked).
- Reset low during PROG2 after programming 7 -> Combo1/Combo2 return to 2/3, State=CLEAR, all outputs at reset values.
